// File: rtl/sar_search_pkg.sv
// ----------------------------------------------------------------------------
// sar_search_pkg
// Shared definitions for the binary-search initiator:
//   - state_t       : controller state encoding (IDLE, PROBE, DONE), 2 bits
//   - DEFAULT_WIDTH : default bit width of guess/result
// ----------------------------------------------------------------------------
package sar_search_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/comparator.sv
// ----------------------------------------------------------------------------
// comparator
// Combinational magnitude comparator answering a search initiator.
// Ports:
//   A        in  WIDTH  value under test (the hidden target)
//   B        in  WIDTH  candidate value
//   A_grt_B  out 1      A > B
//   A_less_B out 1      A < B
//   A_eq_B   out 1      A == B
// ----------------------------------------------------------------------------
module comparator #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             A_grt_B,
    output logic             A_less_B,
    output logic             A_eq_B
);
    assign A_grt_B  = (A > B);
    assign A_less_B = (A < B);
    assign A_eq_B   = (A == B);
endmodule

// File: rtl/sar_search.sv
// ----------------------------------------------------------------------------
// sar_search
// Sequential binary-search initiator. Drives midpoint guesses of a [lo,hi]
// window to an external magnitude comparator and narrows the window from the
// comparator's one-hot flags until equality is reported or the search aborts.
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   start         begin a search (only looked at in IDLE)
//   A_grt_B       comparator: target > guess
//   A_less_B      comparator: target < guess
//   A_eq_B        comparator: target == guess
//   guess         current probe (0 outside PROBE)
//   guess_valid   guess is a live probe
//   busy          search in progress
//   done          one-cycle end-of-search pulse
//   error         qualifies done: search aborted
//   result        found value, held until the next start
//   dbg_state     current controller state
// Handshake: a probe is live while guess_valid is high; the comparator answers
// combinationally in the same cycle and the flags are consumed at the next
// rising edge, so every PROBE cycle is exactly one probe.
// ----------------------------------------------------------------------------
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             A_grt_B,
    input  logic             A_less_B,
    input  logic             A_eq_B,
    output logic [WIDTH-1:0] guess,
    output logic             guess_valid,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output state_t           dbg_state
);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_lo, w_lo_n;
    logic [WIDTH-1:0] r_hi, w_hi_n;
    logic [WIDTH-1:0] r_result, w_result_n;
    logic             r_error, w_error_n;

    // Midpoint taken from a WIDTH+1 bit sum so lo+hi never wraps.
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mid;
    logic [WIDTH:0]   w_lo_inc;   // guess+1 with carry, so guess==MAX shows as > hi
    logic [WIDTH-1:0] w_hi_dec;
    logic [2:0]       w_flags;

    assign w_sum    = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_mid    = w_sum[WIDTH:1];
    assign w_lo_inc = {1'b0, w_mid} + {1'b0, ONE_W};
    assign w_hi_dec = w_mid - ONE_W;
    assign w_flags  = {A_grt_B, A_less_B, A_eq_B};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_lo     <= w_lo_n;
            r_hi     <= w_hi_n;
            r_result <= w_result_n;
            r_error  <= w_error_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_lo_n     = r_lo;
        w_hi_n     = r_hi;
        w_result_n = r_result;
        w_error_n  = r_error;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_lo_n    = '0;
                    w_hi_n    = MAX_VAL;
                    w_error_n = 1'b0;
                    w_state_n = ST_PROBE;
                end
            end
            ST_PROBE: begin
                case (w_flags)
                    3'b001: begin
                        w_result_n = w_mid;
                        w_error_n  = 1'b0;
                        w_state_n  = ST_DONE;
                    end
                    3'b100: begin
                        // Covers both guess==MAX and an empty window (lo>hi).
                        if (w_lo_inc > {1'b0, r_hi}) begin
                            w_error_n = 1'b1;
                            w_state_n = ST_DONE;
                        end else begin
                            w_lo_n = w_lo_inc[WIDTH-1:0];
                        end
                    end
                    3'b010: begin
                        if ((w_mid == '0) || (r_lo > w_hi_dec)) begin
                            w_error_n = 1'b1;
                            w_state_n = ST_DONE;
                        end else begin
                            w_hi_n = w_hi_dec;
                        end
                    end
                    default: begin
                        // Flags not one-hot: comparator answer is unusable.
                        w_error_n = 1'b1;
                        w_state_n = ST_DONE;
                    end
                endcase
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign guess_valid = (r_state == ST_PROBE);
    assign busy        = (r_state == ST_PROBE);
    assign guess       = (r_state == ST_PROBE) ? w_mid : '0;
    assign done        = (r_state == ST_DONE);
    assign error       = r_error;
    assign result      = r_result;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;
  import sar_search_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] target = 4'd0;
  logic       force_en = 1'b0;
  logic [2:0] force_val = 3'b000;  // {grt, less, eq}

  logic       c_grt, c_less, c_eq;
  logic       f_grt, f_less, f_eq;
  logic [3:0] guess, result;
  logic       guess_valid, busy, done, error;
  state_t     dbg_state;

  int total = 0;
  int bad = 0;
  logic [3:0] last_result = 4'd0;
  logic [3:0] exp_seq [0:5];

  always #5 clk = ~clk;

  comparator #(.WIDTH(4)) u_cmp (
    .A(target), .B(guess),
    .A_grt_B(c_grt), .A_less_B(c_less), .A_eq_B(c_eq)
  );

  assign {f_grt, f_less, f_eq} = force_en ? force_val : {c_grt, c_less, c_eq};

  sar_search #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A_grt_B(f_grt), .A_less_B(f_less), .A_eq_B(f_eq),
    .guess(guess), .guess_valid(guess_valid), .busy(busy),
    .done(done), .error(error), .result(result), .dbg_state(dbg_state)
  );

  task automatic check_idle_outputs(input string name, input logic [3:0] exp_result,
                                    input logic exp_error);
    total++;
    if (guess !== 4'd0 || guess_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        error !== exp_error || result !== exp_result) begin
      bad++;
      $display("FAIL %s: guess=%0d valid=%b busy=%b done=%b error=%b result=%0d, want 0/0/0/0/%b/%0d",
               name, guess, guess_valid, busy, done, error, result, exp_error, exp_result);
    end
  endtask

  // Enters in an IDLE cycle, leaves in the IDLE cycle after the done pulse.
  task automatic run_search(input logic [3:0] tgt, input int n, input bit hold_start,
                            input string name);
    target = tgt;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    for (int k = 0; k < n; k++) begin
      total++;
      if (guess !== exp_seq[k] || guess_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL %s probe%0d: guess=%0d valid=%b busy=%b done=%b, want guess=%0d valid=1 busy=1 done=0",
                 name, k, guess, guess_valid, busy, done, exp_seq[k]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (done !== 1'b1 || error !== 1'b0 || result !== tgt || busy !== 1'b0 || guess_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s done: done=%b error=%b result=%0d busy=%b valid=%b, want 1/0/%0d/0/0",
               name, done, error, result, busy, guess_valid, tgt);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check_idle_outputs({name, " after_done"}, tgt, 1'b0);
    last_result = tgt;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    check_idle_outputs("reset_async", 4'd0, 1'b0);
    @(posedge clk); #1;
    check_idle_outputs("reset_held", 4'd0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("idle_no_start", 4'd0, 1'b0);
  endtask

  task automatic test_target_9;
    exp_seq[0] = 4'd7; exp_seq[1] = 4'd11; exp_seq[2] = 4'd9;
    run_search(4'd9, 3, 1'b0, "target9");
  endtask

  task automatic test_target_15;
    exp_seq[0] = 4'd7; exp_seq[1] = 4'd11; exp_seq[2] = 4'd13;
    exp_seq[3] = 4'd14; exp_seq[4] = 4'd15;
    run_search(4'd15, 5, 1'b0, "target15");
  endtask

  task automatic test_target_0;
    exp_seq[0] = 4'd7; exp_seq[1] = 4'd3; exp_seq[2] = 4'd1; exp_seq[3] = 4'd0;
    run_search(4'd0, 4, 1'b0, "target0");
  endtask

  // Plain binary search gives the expected probe sequence per target.
  task automatic test_sweep;
    for (int t = 0; t < 16; t++) begin
      int lo, hi, mid, n;
      lo = 0; hi = 15; n = 0;
      while (n < 6) begin
        mid = (lo + hi) / 2;
        exp_seq[n] = mid[3:0];
        n++;
        if (mid == t) break;
        if (t > mid) lo = mid + 1;
        else hi = mid - 1;
      end
      run_search(t[3:0], n, 1'b0, $sformatf("sweep%0d", t));
    end
  endtask

  task automatic test_flag_error(input logic [2:0] fv, input string name);
    logic [3:0] prev;
    prev = last_result;
    target = 4'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (guess !== 4'd7 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s probe0: guess=%0d busy=%b, want 7/1", name, guess, busy);
    end
    @(posedge clk); #1;
    total++;
    if (guess !== 4'd11 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s probe1: guess=%0d busy=%b, want 11/1", name, guess, busy);
    end
    force_en = 1'b1;
    force_val = fv;
    @(posedge clk); #1;
    force_en = 1'b0;
    total++;
    if (done !== 1'b1 || error !== 1'b1 || result !== prev || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s done: done=%b error=%b result=%0d busy=%b, want 1/1/%0d/0",
               name, done, error, result, busy, prev);
    end
    @(posedge clk); #1;
    check_idle_outputs({name, " error_held"}, prev, 1'b1);
  endtask

  task automatic test_reset_mid_probe;
    target = 4'd12;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (guess !== 4'd13 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid probe2: guess=%0d busy=%b, want 13/1", guess, busy);
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid immediate", 4'd0, 1'b0);
    @(posedge clk); #1;
    check_idle_outputs("rst_mid no_done", 4'd0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("rst_mid released", 4'd0, 1'b0);
    exp_seq[0] = 4'd7; exp_seq[1] = 4'd3; exp_seq[2] = 4'd5;
    run_search(4'd5, 3, 1'b0, "after_rst target5");
  endtask

  // start held high through PROBE and DONE, dropped in the following IDLE cycle.
  task automatic test_start_ignored;
    exp_seq[0] = 4'd7; exp_seq[1] = 4'd3; exp_seq[2] = 4'd1; exp_seq[3] = 4'd2;
    run_search(4'd2, 4, 1'b1, "start_ignored");
    @(posedge clk); #1;
    check_idle_outputs("start_ignored stays_idle", 4'd2, 1'b0);
  endtask

  task automatic test_back_to_back;
    exp_seq[0] = 4'd7;
    run_search(4'd7, 1, 1'b0, "b2b first");
    exp_seq[0] = 4'd7; exp_seq[1] = 4'd11; exp_seq[2] = 4'd13; exp_seq[3] = 4'd12;
    run_search(4'd12, 4, 1'b0, "b2b second");
  endtask

  initial begin
    test_reset();
    test_target_9();
    test_target_15();
    test_target_0();
    test_sweep();
    test_flag_error(3'b000, "flags000");
    test_flag_error(3'b110, "flags110");
    test_target_9();
    test_reset_mid_probe();
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
